// File: rtl/mayday_input_map_if.sv
// Control bundle between the keyboard/pad front end and the Mayday core:
// raw PS/2 key events and pad buttons in, registered core controls out.
interface mayday_input_map_if;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;

   logic        btn_up;
   logic        btn_down;
   logic        btn_right;
   logic        btn_ffire;
   logic        btn_bfire;
   logic        btn_mayday;
   logic        btn_one_player;
   logic        btn_two_players;
   logic        btn_advance;
   logic        btn_auto_up;
   logic        btn_service;
   logic        btn_left_coin;

   // Drives the raw inputs and observes the controls (frame side or bench).
   modport master (
      output ps2_key, joystick_0, joystick_1,
      input  btn_up, btn_down, btn_right, btn_ffire, btn_bfire, btn_mayday,
             btn_one_player, btn_two_players, btn_advance, btn_auto_up,
             btn_service, btn_left_coin
   );

   // Consumes the raw inputs and produces the controls (mapper side).
   modport slave (
      input  ps2_key, joystick_0, joystick_1,
      output btn_up, btn_down, btn_right, btn_ffire, btn_bfire, btn_mayday,
             btn_one_player, btn_two_players, btn_advance, btn_auto_up,
             btn_service, btn_left_coin
   );
endinterface

// File: rtl/mayday_input_map.sv
// Maps PS/2 key events and two pads onto Mayday core controls, and turns a
// start-button rising edge into one fixed-width coin pulse followed by a dead time.
module mayday_input_map #(
   parameter logic [23:0] COIN_CYCLES    = 24'd1000000,
   parameter logic [23:0] HOLDOFF_CYCLES = 24'd2000000
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   mayday_input_map_if.slave  io_bus
);

   localparam int K_UP     = 0;
   localparam int K_DOWN   = 1;
   localparam int K_RIGHT  = 2;
   localparam int K_LEFT   = 3;
   localparam int K_BFIRE  = 4;
   localparam int K_FFIRE  = 5;
   localparam int K_MAYDAY = 6;
   localparam int K_ONE    = 7;
   localparam int K_TWO    = 8;
   localparam int K_ADV    = 9;
   localparam int K_AUTO   = 10;
   localparam int K_SVC    = 11;
   localparam int NKEYS    = 12;

   localparam int B_UP     = 0;
   localparam int B_DOWN   = 1;
   localparam int B_RIGHT  = 2;
   localparam int B_FFIRE  = 3;
   localparam int B_BFIRE  = 4;
   localparam int B_MAYDAY = 5;
   localparam int B_ONE    = 6;
   localparam int B_TWO    = 7;
   localparam int B_ADV    = 8;
   localparam int B_AUTO   = 9;
   localparam int B_SVC    = 10;
   localparam int NBTNS    = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COIN    = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   logic              armed_q, armed_d;
   logic              tog_q, tog_d;
   logic [NKEYS-1:0]  key_q, key_d;
   logic [8:0]        joy_q, joy_d;
   logic [NBTNS-1:0]  btn_q, btn_d;
   logic              start_prev_q;
   logic              coin_q, coin_d;
   state_t            state_q, state_d;
   logic [23:0]       cnt_q, cnt_d;

   logic              key_event;
   logic [NKEYS-1:0]  key_hit;
   logic [15:0]       joy_or;
   logic              start_any;
   logic              start_rise;
   logic              unused_joy;

   // The frame flips bit 10 once per key event; the first cycle out of reset
   // only captures its level so a stale toggle is not taken as a keypress.
   assign key_event = armed_q & (io_bus.ps2_key[10] != tog_q);
   assign armed_d   = 1'b1;
   assign tog_d     = io_bus.ps2_key[10];

   // Movement/fire keys accept either prefix; the rest must be unextended.
   always_comb begin
      key_hit = '0;
      case (io_bus.ps2_key[7:0])
         8'h75:   key_hit[K_UP]     = 1'b1;
         8'h72:   key_hit[K_DOWN]   = 1'b1;
         8'h74:   key_hit[K_RIGHT]  = 1'b1;
         8'h6B:   key_hit[K_LEFT]   = 1'b1;
         8'h14:   key_hit[K_BFIRE]  = 1'b1;
         8'h11:   key_hit[K_FFIRE]  = 1'b1;
         8'h29:   key_hit[K_MAYDAY] = ~io_bus.ps2_key[8];
         8'h05:   key_hit[K_ONE]    = ~io_bus.ps2_key[8];
         8'h06:   key_hit[K_TWO]    = ~io_bus.ps2_key[8];
         8'h1C:   key_hit[K_ADV]    = ~io_bus.ps2_key[8];
         8'h3C:   key_hit[K_AUTO]   = ~io_bus.ps2_key[8];
         8'h1B:   key_hit[K_SVC]    = ~io_bus.ps2_key[8];
         default: key_hit = '0;
      endcase
   end

   always_comb begin
      key_d = key_q;
      if (key_event) begin
         key_d = (key_q & ~key_hit) | (key_hit & {NKEYS{io_bus.ps2_key[9]}});
      end
   end

   assign joy_or     = io_bus.joystick_0 | io_bus.joystick_1;
   assign joy_d      = joy_or[8:0];
   assign unused_joy = &{1'b0, joy_or[15:9]};

   // Mayday turns around in place, so left folds onto the right control.
   always_comb begin
      btn_d           = '0;
      btn_d[B_UP]     = key_q[K_UP]     | joy_q[3];
      btn_d[B_DOWN]   = key_q[K_DOWN]   | joy_q[2];
      btn_d[B_RIGHT]  = key_q[K_RIGHT]  | key_q[K_LEFT] | joy_q[0] | joy_q[1];
      btn_d[B_FFIRE]  = key_q[K_FFIRE]  | joy_q[4];
      btn_d[B_BFIRE]  = key_q[K_BFIRE]  | joy_q[5];
      btn_d[B_MAYDAY] = key_q[K_MAYDAY] | joy_q[6];
      btn_d[B_ONE]    = key_q[K_ONE]    | joy_q[7];
      btn_d[B_TWO]    = key_q[K_TWO]    | joy_q[8];
      btn_d[B_ADV]    = key_q[K_ADV];
      btn_d[B_AUTO]   = key_q[K_AUTO];
      btn_d[B_SVC]    = key_q[K_SVC];
   end

   // Starts are taken from the registered outputs so the coin logic sees
   // exactly what the core sees.
   assign start_any  = btn_q[B_ONE] | btn_q[B_TWO];
   assign start_rise = start_any & ~start_prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d = ST_COIN;
               cnt_d   = COIN_CYCLES - 24'd1;
            end
         end
         ST_COIN: begin
            if (cnt_q == 24'd0) begin
               state_d = ST_HOLDOFF;
               cnt_d   = HOLDOFF_CYCLES - 24'd1;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q == 24'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 24'd0;
         end
      endcase
   end

   // Registering the next-state decode keeps the pulse aligned with COIN.
   assign coin_d = (state_d == ST_COIN);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         armed_q      <= 1'b0;
         tog_q        <= 1'b0;
         key_q        <= '0;
         joy_q        <= '0;
         btn_q        <= '0;
         start_prev_q <= 1'b0;
         coin_q       <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= 24'd0;
      end else begin
         armed_q      <= armed_d;
         tog_q        <= tog_d;
         key_q        <= key_d;
         joy_q        <= joy_d;
         btn_q        <= btn_d;
         start_prev_q <= start_any;
         coin_q       <= coin_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
      end
   end

   assign io_bus.btn_up          = btn_q[B_UP];
   assign io_bus.btn_down        = btn_q[B_DOWN];
   assign io_bus.btn_right       = btn_q[B_RIGHT];
   assign io_bus.btn_ffire       = btn_q[B_FFIRE];
   assign io_bus.btn_bfire       = btn_q[B_BFIRE];
   assign io_bus.btn_mayday      = btn_q[B_MAYDAY];
   assign io_bus.btn_one_player  = btn_q[B_ONE];
   assign io_bus.btn_two_players = btn_q[B_TWO];
   assign io_bus.btn_advance     = btn_q[B_ADV];
   assign io_bus.btn_auto_up     = btn_q[B_AUTO];
   assign io_bus.btn_service     = btn_q[B_SVC];
   assign io_bus.btn_left_coin   = coin_q;

endmodule
